// File: rtl/linear_arb_pkg.sv
// Shared state type and sizing helpers for the linear job arbiter.
package linear_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int PERF_JOB_W  = 16;
  localparam int PERF_BUSY_W = 32;

  // Width that holds the largest beat target of any stream (never below 1 bit).
  function automatic int beat_cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping, as a one-hot grant.
module rr_arbiter_onehot #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic [N-1:0] mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] sel;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign mask[gi] = (PTR_W'(gi) >= ptr);
  end

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  assign req_hi = req & mask;
  assign sel    = (|req_hi) ? req_hi : req;
  assign grant  = sel & (~sel + N'(1));

endmodule

// File: rtl/linear_job_arbiter.sv
// Job-granular round-robin sharing of one fixed_linear layer between NUM_REQ requesters.
// Define LINEAR_ARB_PERF_EN to add saturating perf_jobs / perf_busy counters.
module linear_job_arbiter
  import linear_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int IN_W       = 64,
  parameter int WT_W       = 256,
  parameter int BIAS_W     = 64,
  parameter int OUT_W      = 64,
  parameter int IN_BEATS   = 25,
  parameter int WT_BEATS   = 25,
  parameter int BIAS_BEATS = 5,
  parameter int OUT_BEATS  = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         job_req,
  output logic [NUM_REQ-1:0]         job_grant,
  output logic [NUM_REQ-1:0]         job_done,
`ifdef LINEAR_ARB_PERF_EN
  output logic [NUM_REQ*PERF_JOB_W-1:0] perf_jobs,
  output logic [PERF_BUSY_W-1:0]     perf_busy,
`endif
  input  logic [NUM_REQ*IN_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]         req_data_valid,
  output logic [NUM_REQ-1:0]         req_data_ready,
  input  logic [NUM_REQ*WT_W-1:0]    req_weight,
  input  logic [NUM_REQ-1:0]         req_weight_valid,
  output logic [NUM_REQ-1:0]         req_weight_ready,
  input  logic [NUM_REQ*BIAS_W-1:0]  req_bias,
  input  logic [NUM_REQ-1:0]         req_bias_valid,
  output logic [NUM_REQ-1:0]         req_bias_ready,
  output logic [OUT_W-1:0]           req_out,
  output logic [NUM_REQ-1:0]         req_out_valid,
  input  logic [NUM_REQ-1:0]         req_out_ready,
  output logic [IN_W-1:0]            lin_data,
  output logic                       lin_data_valid,
  input  logic                       lin_data_ready,
  output logic [WT_W-1:0]            lin_weight,
  output logic                       lin_weight_valid,
  input  logic                       lin_weight_ready,
  output logic [BIAS_W-1:0]          lin_bias,
  output logic                       lin_bias_valid,
  input  logic                       lin_bias_ready,
  input  logic [OUT_W-1:0]           lin_out,
  input  logic                       lin_out_valid,
  output logic                       lin_out_ready
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = beat_cnt_w(IN_BEATS, WT_BEATS, BIAS_BEATS, OUT_BEATS);
  localparam logic [CNT_W-1:0] IN_T   = CNT_W'(IN_BEATS);
  localparam logic [CNT_W-1:0] WT_T   = CNT_W'(WT_BEATS);
  localparam logic [CNT_W-1:0] BIAS_T = CNT_W'(BIAS_BEATS);
  localparam logic [CNT_W-1:0] OUT_T  = CNT_W'(OUT_BEATS);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_in_q, cnt_in_d, cnt_wt_q, cnt_wt_d;
  logic [CNT_W-1:0]   cnt_bias_q, cnt_bias_d, cnt_out_q, cnt_out_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               busy, fwd_in, fwd_wt, fwd_bias;
  logic               hs_in, hs_wt, hs_bias, hs_out, all_done;

  logic [IN_W-1:0]   data_arr [NUM_REQ];
  logic [WT_W-1:0]   wt_arr   [NUM_REQ];
  logic [BIAS_W-1:0] bias_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*IN_W +: IN_W];
    assign wt_arr[gi]   = req_weight[gi*WT_W +: WT_W];
    assign bias_arr[gi] = req_bias[gi*BIAS_W +: BIAS_W];
  end

  rr_arbiter_onehot #(
    .N     (NUM_REQ),
    .PTR_W (IDX_W)
  ) u_rr (
    .req   (job_req),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) arb_idx = IDX_W'(i);
    end
  end

  // A stream stops forwarding once its quota is met so excess beats stall at the owner.
  assign busy      = (state_q == BUSY);
  assign fwd_in    = busy && (cnt_in_q != IN_T);
  assign fwd_wt    = busy && (cnt_wt_q != WT_T);
  assign fwd_bias  = busy && (cnt_bias_q != BIAS_T);
  assign job_grant = grant_q;

  assign hs_in   = fwd_in && req_data_valid[owner_q] && lin_data_ready;
  assign hs_wt   = fwd_wt && req_weight_valid[owner_q] && lin_weight_ready;
  assign hs_bias = fwd_bias && req_bias_valid[owner_q] && lin_bias_ready;
  assign hs_out  = busy && lin_out_valid && req_out_ready[owner_q];

  always_comb begin
    lin_data         = '0;
    lin_data_valid   = 1'b0;
    req_data_ready   = '0;
    lin_weight       = '0;
    lin_weight_valid = 1'b0;
    req_weight_ready = '0;
    lin_bias         = '0;
    lin_bias_valid   = 1'b0;
    req_bias_ready   = '0;
    req_out          = '0;
    req_out_valid    = '0;
    lin_out_ready    = 1'b0;
    if (fwd_in) begin
      lin_data                = data_arr[owner_q];
      lin_data_valid          = req_data_valid[owner_q];
      req_data_ready[owner_q] = lin_data_ready;
    end
    if (fwd_wt) begin
      lin_weight                = wt_arr[owner_q];
      lin_weight_valid          = req_weight_valid[owner_q];
      req_weight_ready[owner_q] = lin_weight_ready;
    end
    if (fwd_bias) begin
      lin_bias                = bias_arr[owner_q];
      lin_bias_valid          = req_bias_valid[owner_q];
      req_bias_ready[owner_q] = lin_bias_ready;
    end
    if (busy) begin
      req_out                = lin_out;
      req_out_valid[owner_q] = lin_out_valid;
      lin_out_ready          = req_out_ready[owner_q];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    job_done   = '0;
    cnt_in_d   = cnt_in_q + CNT_W'(hs_in);
    cnt_wt_d   = cnt_wt_q + CNT_W'(hs_wt);
    cnt_bias_d = cnt_bias_q + CNT_W'(hs_bias);
    cnt_out_d  = cnt_out_q + CNT_W'(hs_out);
    all_done   = (cnt_in_d == IN_T) && (cnt_wt_d == WT_T) &&
                 (cnt_bias_d == BIAS_T) && (cnt_out_d == OUT_T);
    case (state_q)
      IDLE: begin
        if (|job_req) begin
          grant_d = arb_grant;
          owner_d = arb_idx;
          ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (all_done) begin
          job_done   = grant_q;
          grant_d    = '0;
          cnt_in_d   = '0;
          cnt_wt_d   = '0;
          cnt_bias_d = '0;
          cnt_out_d  = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_in_q   <= '0;
      cnt_wt_q   <= '0;
      cnt_bias_q <= '0;
      cnt_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_in_q   <= cnt_in_d;
      cnt_wt_q   <= cnt_wt_d;
      cnt_bias_q <= cnt_bias_d;
      cnt_out_q  <= cnt_out_d;
    end
  end

`ifdef LINEAR_ARB_PERF_EN
  logic [PERF_BUSY_W-1:0] perf_busy_q, perf_busy_d;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
    logic [PERF_JOB_W-1:0] jobs_q, jobs_d;
    always_comb begin
      jobs_d = jobs_q;
      if (job_done[gi] && (jobs_q != '1)) jobs_d = jobs_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) jobs_q <= '0;
      else      jobs_q <= jobs_d;
    end
    assign perf_jobs[gi*PERF_JOB_W +: PERF_JOB_W] = jobs_q;
  end

  always_comb begin
    perf_busy_d = perf_busy_q;
    if (busy && (perf_busy_q != '1)) perf_busy_d = perf_busy_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_busy_q <= '0;
    else      perf_busy_q <= perf_busy_d;
  end

  assign perf_busy = perf_busy_q;
`endif

endmodule

// File: tb/tb_linear_job_arbiter.sv
// Directed bench for linear_job_arbiter with a job-level reference model checked every cycle.
module tb_linear_job_arbiter;

  localparam int N   = 3;
  localparam int W   = 8;
  localparam int DW  = N * W;
  localparam int INB = 4;
  localparam int WTB = 8;
  localparam int BB  = 2;
  localparam int OB  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]  job_req, job_grant, job_done;
  logic [DW-1:0] req_data, req_weight, req_bias;
  logic [N-1:0]  req_data_valid, req_data_ready, req_weight_valid, req_weight_ready;
  logic [N-1:0]  req_bias_valid, req_bias_ready, req_out_valid, req_out_ready;
  logic [W-1:0]  req_out, lin_data, lin_weight, lin_bias, lin_out;
  logic          lin_data_valid, lin_data_ready, lin_weight_valid, lin_weight_ready;
  logic          lin_bias_valid, lin_bias_ready, lin_out_valid, lin_out_ready;
`ifdef LINEAR_ARB_PERF_EN
  logic [N*16-1:0] perf_jobs;
  logic [31:0]     perf_busy;
`endif

  linear_job_arbiter #(
    .NUM_REQ(N), .IN_W(W), .WT_W(W), .BIAS_W(W), .OUT_W(W),
    .IN_BEATS(INB), .WT_BEATS(WTB), .BIAS_BEATS(BB), .OUT_BEATS(OB)
  ) dut (
    .clk(clk), .rst(rst), .job_req(job_req), .job_grant(job_grant), .job_done(job_done),
`ifdef LINEAR_ARB_PERF_EN
    .perf_jobs(perf_jobs), .perf_busy(perf_busy),
`endif
    .req_data(req_data), .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
    .req_weight(req_weight), .req_weight_valid(req_weight_valid), .req_weight_ready(req_weight_ready),
    .req_bias(req_bias), .req_bias_valid(req_bias_valid), .req_bias_ready(req_bias_ready),
    .req_out(req_out), .req_out_valid(req_out_valid), .req_out_ready(req_out_ready),
    .lin_data(lin_data), .lin_data_valid(lin_data_valid), .lin_data_ready(lin_data_ready),
    .lin_weight(lin_weight), .lin_weight_valid(lin_weight_valid), .lin_weight_ready(lin_weight_ready),
    .lin_bias(lin_bias), .lin_bias_valid(lin_bias_valid), .lin_bias_ready(lin_bias_ready),
    .lin_out(lin_out), .lin_out_valid(lin_out_valid), .lin_out_ready(lin_out_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tgt(input int s);
    case (s)
      0:       return INB;
      1:       return WTB;
      2:       return BB;
      default: return OB;
    endcase
  endfunction

  // Reference model: owner (-1 when idle), beats taken per stream, next preferred requester.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt [4];
  int m_busy  = 0;
  logic [W-1:0] sb_q [$];

  task automatic model_step();
    logic [N-1:0]  rv [3];
    logic [N-1:0]  rr_act [3];
    logic [DW-1:0] rd [3];
    logic          lr [3];
    logic          lv_act [3];
    logic [W-1:0]  ld_act [3];
    string         nm [3];
    logic [W-1:0]  exp_beat;
    bit fwd, busy, done;
    int o;
    rv     = '{req_data_valid, req_weight_valid, req_bias_valid};
    rr_act = '{req_data_ready, req_weight_ready, req_bias_ready};
    rd     = '{req_data, req_weight, req_bias};
    lr     = '{lin_data_ready, lin_weight_ready, lin_bias_ready};
    lv_act = '{lin_data_valid, lin_weight_valid, lin_bias_valid};
    ld_act = '{lin_data, lin_weight, lin_bias};
    nm     = '{"data", "weight", "bias"};
    busy   = (m_owner >= 0);
    o      = busy ? m_owner : 0;

    chk("grant", 64'(job_grant), busy ? 64'(N'(1) << o) : 64'(0));
    for (int s = 0; s < 3; s++) begin
      fwd = busy && (m_cnt[s] < tgt(s));
      chk({nm[s], "_valid"}, 64'(lv_act[s]), fwd ? 64'(rv[s][o]) : 64'(0));
      chk({nm[s], "_ready"}, 64'(rr_act[s]), (fwd && lr[s]) ? 64'(N'(1) << o) : 64'(0));
      if (fwd) chk({nm[s], "_bus"}, 64'(ld_act[s]), 64'(rd[s][o*W +: W]));
      if (fwd && rv[s][o] && lr[s]) m_cnt[s]++;
    end
    chk("out_valid", 64'(req_out_valid), (busy && lin_out_valid) ? 64'(N'(1) << o) : 64'(0));
    chk("out_ready", 64'(lin_out_ready), 64'(busy && req_out_ready[o]));
    if (busy) chk("out_bus", 64'(req_out), 64'(lin_out));
    if (busy && lin_out_valid && req_out_ready[o]) m_cnt[3]++;

    // Result scoreboard: every beat leaving the layer must reach exactly the owner, in order.
    if (lin_out_valid && lin_out_ready) sb_q.push_back(lin_out);
    for (int i = 0; i < N; i++) begin
      if (req_out_valid[i] && req_out_ready[i]) begin
        chk("out_dest", 64'(i), 64'(o));
        exp_beat = (sb_q.size() > 0) ? sb_q.pop_front() : ~req_out;
        chk("out_order", 64'(req_out), 64'(exp_beat));
      end
    end

    done = busy && (m_cnt[0] == INB) && (m_cnt[1] == WTB) && (m_cnt[2] == BB) && (m_cnt[3] == OB);
    chk("done", 64'(job_done), done ? 64'(N'(1) << o) : 64'(0));
    if (busy) m_busy++;
    if (done) begin
      m_owner = -1;
      m_cnt   = '{default: 0};
    end else if (!busy) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (job_req[c]) begin
          m_owner = c;
          m_ptr   = (c + 1) % N;
          break;
        end
      end
    end
  endtask

  initial begin
    m_cnt = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = '{default: 0};
        m_busy  = 0;
        sb_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Stimulus state (derived from DUT outputs only to shape traffic, never for expectations).
  bit           stall_en    = 1'b0;
  bit           check_excess = 1'b0;
  int           job_hs [4];
  int           out_seq     = 0;
  int           layer_given = 0;
  logic [N-1:0] seen_grant, seen_done;

  task automatic drive();
    req_data         = DW'($urandom());
    req_weight       = DW'($urandom());
    req_bias         = DW'($urandom());
    req_data_valid   = stall_en ? N'($urandom()) : '1;
    req_weight_valid = stall_en ? N'($urandom()) : '1;
    req_bias_valid   = stall_en ? N'($urandom()) : '1;
    req_out_ready    = stall_en ? N'($urandom()) : '1;
    lin_data_ready   = stall_en ? 1'($urandom()) : 1'b1;
    lin_weight_ready = stall_en ? 1'($urandom()) : 1'b1;
    lin_bias_ready   = stall_en ? 1'($urandom()) : 1'b1;
    lin_out          = W'(out_seq + 160);
    lin_out_valid    = 1'b0;
    if (job_grant != '0 && layer_given < OB) lin_out_valid = stall_en ? 1'($urandom()) : 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    if (lin_data_valid && lin_data_ready) job_hs[0]++;
    if (lin_weight_valid && lin_weight_ready) job_hs[1]++;
    if (lin_bias_valid && lin_bias_ready) job_hs[2]++;
    if (lin_out_valid && lin_out_ready) begin
      job_hs[3]++;
      out_seq++;
      layer_given++;
    end
    if (job_grant != '0 && seen_grant == '0) seen_grant = job_grant;
    if (job_done != '0) seen_done = job_done;
    if (job_grant == '0) layer_given = 0;
    @(posedge clk);
    #1;
    drive();
    #1;
  endtask

  task automatic clear_job();
    job_hs     = '{default: 0};
    seen_grant = '0;
    seen_done  = '0;
  endtask

  task automatic wait_done(input string tag, output logic [N-1:0] g);
    int cyc;
    cyc = 0;
    clear_job();
    while (seen_done == '0 && cyc < 600) begin
      step();
      cyc++;
      if (check_excess && job_hs[0] == INB && job_grant[0] && job_hs[1] < WTB) begin
        chk({tag, "_excess_valid"}, 64'(lin_data_valid), 64'(0));
        chk({tag, "_excess_ready"}, 64'(req_data_ready[0]), 64'(0));
      end
    end
    if (seen_done == '0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no job_done within 600 cycles", tag);
    end
    chk({tag, "_done_owner"}, 64'(seen_done), 64'(seen_grant));
    chk({tag, "_n_data"}, 64'(job_hs[0]), 64'(INB));
    chk({tag, "_n_weight"}, 64'(job_hs[1]), 64'(WTB));
    chk({tag, "_n_bias"}, 64'(job_hs[2]), 64'(BB));
    chk({tag, "_n_out"}, 64'(job_hs[3]), 64'(OB));
    g = seen_grant;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  logic [N-1:0] g;
  logic [N-1:0] exp_t2 [4];
  logic [N-1:0] pat_t4 [4];
  logic [N-1:0] exp_t4 [4];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t2 = '{3'b001, 3'b010, 3'b100, 3'b001};
    pat_t4 = '{3'b101, 3'b110, 3'b011, 3'b010};
    exp_t4 = '{3'b100, 3'b010, 3'b001, 3'b010};
    job_req = '0;
    clear_job();
    drive();
    #2 rst = 1'b0;
    repeat (3) step();
    chk("rst_grant", 64'(job_grant), 64'(0));
    chk("rst_done", 64'(job_done), 64'(0));
    chk("rst_lin_valid", 64'({lin_data_valid, lin_weight_valid, lin_bias_valid}), 64'(0));
    chk("rst_req_ready", 64'({req_data_ready, req_weight_ready, req_bias_ready}), 64'(0));
    chk("rst_out", 64'({req_out_valid, lin_out_ready, req_out}), 64'(0));
    rst = 1'b1;
    repeat (2) step();

    // Single job from requester 0; its data valid stays high past its quota.
    job_req = 3'b001;
    chk("t1_grant_before", 64'(job_grant), 64'(0));
    step();
    chk("t1_grant_after", 64'(job_grant), 64'(3'b001));
    check_excess = 1'b1;
    wait_done("t1", g);
    check_excess = 1'b0;
    chk("t1_owner", 64'(g), 64'(3'b001));
    job_req = '0;
    chk("t1_grant_clear", 64'(job_grant), 64'(0));
    step();

    // All three requesting continuously from a fresh pointer.
    pulse_reset();
    job_req = 3'b111;
    for (int j = 0; j < 4; j++) begin
      wait_done("t2", g);
      chk($sformatf("t2_grant%0d", j), 64'(g), 64'(exp_t2[j]));
    end
    job_req = '0;
    repeat (2) step();

    // Random stalls on every handshake, varying request sets.
    stall_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      job_req = pat_t4[j];
      wait_done("t4", g);
      job_req = '0;
      chk($sformatf("t4_grant%0d", j), 64'(g), 64'(exp_t4[j]));
      step();
    end
    stall_en = 1'b0;
    repeat (2) step();

    // Reset in the middle of a job, then a full fresh job.
    job_req = 3'b001;
    clear_job();
    for (int c = 0; c < 20 && job_hs[0] < 2; c++) step();
    chk("t5_data_before_rst", 64'(job_hs[0]), 64'(2));
    rst = 1'b0;
    #1;
    chk("t5_rst_grant", 64'(job_grant), 64'(0));
    chk("t5_rst_done", 64'(job_done), 64'(0));
    chk("t5_rst_data_valid", 64'(lin_data_valid), 64'(0));
    chk("t5_rst_data_ready", 64'(req_data_ready), 64'(0));
    job_req = '0;
    step();
    step();
    rst = 1'b1;
    step();
    job_req = 3'b001;
    wait_done("t5", g);
    job_req = '0;
    chk("t5_owner", 64'(g), 64'(3'b001));
    repeat (2) step();

`ifdef LINEAR_ARB_PERF_EN
    pulse_reset();
    job_req = 3'b010;
    wait_done("t6a", g);
    wait_done("t6b", g);
    job_req = '0;
    repeat (3) step();
    chk("perf_jobs1", 64'(perf_jobs[16 +: 16]), 64'(2));
    chk("perf_jobs_other", 64'({perf_jobs[32 +: 16], perf_jobs[0 +: 16]}), 64'(0));
    chk("perf_busy", 64'(perf_busy), 64'(m_busy));
`endif

    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
